// File: rtl/taillight_pattern_checker.sv
// Monitors the 6-bit taillight pattern bus against the sequencer's legal transition graph.
// Optional build macro TLC_STICKY_ERR_EN makes err_o hold until clr_i or reset.
module taillight_pattern_checker #(
  parameter int CNT_W   = 8,
  parameter int OFF_RUN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [5:0]       pattern_i,
  input  logic             clr_i,
  output logic [1:0]       mode_o,
  output logic             sync_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] sweep_cnt_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HAZ, S_UNSYNC
  } state_t;

  localparam logic [1:0]       MODE_OFF    = 2'd0;
  localparam logic [1:0]       MODE_LEFT   = 2'd1;
  localparam logic [1:0]       MODE_RIGHT  = 2'd2;
  localparam logic [1:0]       MODE_HAZARD = 2'd3;
  localparam logic [3:0]       ZRUN_MAX    = 4'(OFF_RUN);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           r_state, w_state_next, w_dec_state;
  logic             w_dec_legal, w_trans_ok, w_err_evt, w_sweep_evt;
  logic [1:0]       r_mode, w_mode_next;
  logic [3:0]       r_zrun, w_zrun_next;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt, r_sweep_cnt;

  always_comb begin
    w_dec_legal = 1'b1;
    w_dec_state = S_UNSYNC;
    case (pattern_i)
      6'b000000: w_dec_state = S_IDLE;
      6'b001000: w_dec_state = S_L1;
      6'b011000: w_dec_state = S_L2;
      6'b111000: w_dec_state = S_L3;
      6'b000100: w_dec_state = S_R1;
      6'b000110: w_dec_state = S_R2;
      6'b000111: w_dec_state = S_R3;
      6'b111111: w_dec_state = S_HAZ;
      default:   w_dec_legal = 1'b0;
    endcase
  end

  // Coming out of UNSYNC any legal encoding is a clean re-lock.
  always_comb begin
    w_trans_ok = 1'b0;
    case (r_state)
      S_IDLE:   w_trans_ok = (w_dec_state inside {S_IDLE, S_L1, S_R1, S_HAZ});
      S_L1:     w_trans_ok = (w_dec_state inside {S_L2, S_IDLE, S_HAZ});
      S_L2:     w_trans_ok = (w_dec_state inside {S_L3, S_IDLE, S_HAZ});
      S_L3:     w_trans_ok = (w_dec_state inside {S_IDLE, S_HAZ});
      S_R1:     w_trans_ok = (w_dec_state inside {S_R2, S_IDLE, S_HAZ});
      S_R2:     w_trans_ok = (w_dec_state inside {S_R3, S_IDLE, S_HAZ});
      S_R3:     w_trans_ok = (w_dec_state inside {S_IDLE, S_HAZ});
      S_HAZ:    w_trans_ok = (w_dec_state inside {S_IDLE, S_L1, S_R1});
      S_UNSYNC: w_trans_ok = 1'b1;
      default:  w_trans_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_mode_next  = r_mode;
    w_zrun_next  = r_zrun;
    w_err_evt    = 1'b0;
    w_sweep_evt  = 1'b0;
    if (valid_i) begin
      if (pattern_i == 6'b000000)
        w_zrun_next = (r_zrun >= ZRUN_MAX) ? ZRUN_MAX : r_zrun + 4'd1;
      else
        w_zrun_next = 4'd0;

      if (!w_dec_legal) begin
        w_err_evt    = 1'b1;
        w_state_next = S_UNSYNC;
      end else begin
        w_state_next = w_dec_state;
        w_err_evt    = !w_trans_ok;
        w_sweep_evt  = w_trans_ok && (w_dec_state == S_IDLE) &&
                       ((r_state == S_L3) || (r_state == S_R3));
        case (w_dec_state)
          S_L1:    w_mode_next = MODE_LEFT;
          S_R1:    w_mode_next = MODE_RIGHT;
          S_HAZ:   w_mode_next = MODE_HAZARD;
          S_IDLE:  if (w_zrun_next == ZRUN_MAX) w_mode_next = MODE_OFF;
          default: w_mode_next = r_mode;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_OFF;
      r_zrun  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_mode  <= w_mode_next;
      r_zrun  <= w_zrun_next;
    end
  end

  // clr_i outranks any same-cycle event for the flag and both counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_sweep_cnt <= '0;
    end else if (clr_i) begin
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_sweep_cnt <= '0;
    end else begin
`ifdef TLC_STICKY_ERR_EN
      r_err <= r_err | w_err_evt;
`else
      r_err <= w_err_evt;
`endif
      if (w_err_evt && (r_err_cnt != CNT_MAX))
        r_err_cnt <= r_err_cnt + 1'b1;
      if (w_sweep_evt && (r_sweep_cnt != CNT_MAX))
        r_sweep_cnt <= r_sweep_cnt + 1'b1;
    end
  end

  assign mode_o      = r_mode;
  assign sync_o      = (r_state != S_UNSYNC);
  assign err_o       = r_err;
  assign err_cnt_o   = r_err_cnt;
  assign sweep_cnt_o = r_sweep_cnt;

endmodule

// File: tb/tb_taillight_pattern_checker.sv
// Directed-vector bench for taillight_pattern_checker; expectations are hand-derived per scenario.
`timescale 1ns/1ps
module tb_taillight_pattern_checker;

`ifdef TLC_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_i = 1'b0;
  logic [5:0] pattern_i = 6'd0;
  logic       clr_i = 1'b0;
  logic [1:0] mode_o;
  logic       sync_o;
  logic       err_o;
  logic [7:0] err_cnt_o;
  logic [7:0] sweep_cnt_o;

  int tests = 0;
  int fails = 0;

  taillight_pattern_checker #(.CNT_W(8), .OFF_RUN(2)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .pattern_i(pattern_i), .clr_i(clr_i),
    .mode_o(mode_o), .sync_o(sync_o), .err_o(err_o),
    .err_cnt_o(err_cnt_o), .sweep_cnt_o(sweep_cnt_o)
  );

  always #5 clk = ~clk;

  // One accepted sample; outputs are observed at the following negedge.
  task automatic drive_sample(input logic [5:0] p);
    @(negedge clk);
    valid_i = 1'b1; pattern_i = p;
    @(negedge clk);
    valid_i = 1'b0;
    $display("[TB] sample %06b -> mode=%0d sync=%0d err=%0d err_cnt=%0d sweep_cnt=%0d",
             p, mode_o, sync_o, err_o, err_cnt_o, sweep_cnt_o);
  endtask

  task automatic drive_clear();
    @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (mode_o !== 2'd0) begin fails++; $display("FAIL reset_mode: got %0d expected 0", mode_o); end
    tests++; if (sync_o !== 1'b1) begin fails++; $display("FAIL reset_sync: got %0d expected 1", sync_o); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %0d expected 0", err_o); end
    tests++; if (err_cnt_o !== 8'd0 || sweep_cnt_o !== 8'd0) begin fails++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", err_cnt_o, sweep_cnt_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_left_sweep();
    logic [5:0] pats [6] = '{6'o00, 6'o10, 6'o30, 6'o70, 6'o00, 6'o00};
    logic [1:0] exp_mode [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    for (int i = 0; i < 6; i++) begin
      drive_sample(pats[i]);
      tests++; if (mode_o !== exp_mode[i]) begin fails++; $display("FAIL left_mode[%0d]: got %0d expected %0d", i, mode_o, exp_mode[i]); end
    end
    tests++; if (sweep_cnt_o !== 8'd1) begin fails++; $display("FAIL left_sweep_cnt: got %0d expected 1", sweep_cnt_o); end
    tests++; if (err_cnt_o !== 8'd0) begin fails++; $display("FAIL left_err_cnt: got %0d expected 0", err_cnt_o); end
  endtask

  task automatic test_hazard();
    logic [5:0] pats [5] = '{6'o77, 6'o00, 6'o77, 6'o00, 6'o00};
    logic [1:0] exp_mode [5] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    drive_clear();
    for (int i = 0; i < 5; i++) begin
      drive_sample(pats[i]);
      tests++; if (mode_o !== exp_mode[i]) begin fails++; $display("FAIL haz_mode[%0d]: got %0d expected %0d", i, mode_o, exp_mode[i]); end
      tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL haz_err[%0d]: got %0d expected 0", i, err_o); end
    end
    tests++; if (sweep_cnt_o !== 8'd0) begin fails++; $display("FAIL haz_sweep_cnt: got %0d expected 0", sweep_cnt_o); end
  endtask

  task automatic test_skip_step();
    drive_clear();
    drive_sample(6'b000100);
    tests++; if (mode_o !== 2'd2 || err_o !== 1'b0) begin fails++; $display("FAIL skip_r1: got mode=%0d err=%0d expected mode=2 err=0", mode_o, err_o); end
    drive_sample(6'b000111);
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL skip_err_pulse: got %0d expected 1", err_o); end
    tests++; if (err_cnt_o !== 8'd1) begin fails++; $display("FAIL skip_err_cnt: got %0d expected 1", err_cnt_o); end
    tests++; if (mode_o !== 2'd2 || sync_o !== 1'b1) begin fails++; $display("FAIL skip_mode_sync: got mode=%0d sync=%0d expected mode=2 sync=1", mode_o, sync_o); end
    @(negedge clk);
    tests++; if (err_o !== STICKY) begin fails++; $display("FAIL skip_err_after: got %0d expected %0d", err_o, STICKY); end
    drive_sample(6'b000000);
    tests++; if (sweep_cnt_o !== 8'd1) begin fails++; $display("FAIL skip_sweep_cnt: got %0d expected 1", sweep_cnt_o); end
    tests++; if (err_cnt_o !== 8'd1) begin fails++; $display("FAIL skip_err_cnt2: got %0d expected 1", err_cnt_o); end
  endtask

  task automatic test_illegal_encoding();
    drive_sample(6'b010101);
    tests++; if (err_cnt_o !== 8'd2 || err_o !== 1'b1) begin fails++; $display("FAIL illegal_err: got cnt=%0d err=%0d expected cnt=2 err=1", err_cnt_o, err_o); end
    tests++; if (sync_o !== 1'b0 || mode_o !== 2'd2) begin fails++; $display("FAIL illegal_sync_mode: got sync=%0d mode=%0d expected sync=0 mode=2", sync_o, mode_o); end
    drive_sample(6'b001000);
    tests++; if (sync_o !== 1'b1 || mode_o !== 2'd1) begin fails++; $display("FAIL resync: got sync=%0d mode=%0d expected sync=1 mode=1", sync_o, mode_o); end
    tests++; if (err_cnt_o !== 8'd2 || err_o !== STICKY) begin fails++; $display("FAIL resync_err: got cnt=%0d err=%0d expected cnt=2 err=%0d", err_cnt_o, err_o, STICKY); end
  endtask

  task automatic test_saturation_clear();
    drive_clear();
    @(negedge clk);
    valid_i = 1'b1; pattern_i = 6'b010101;
    repeat (300) @(negedge clk);
    valid_i = 1'b0;
    $display("[TB] 300 illegal samples -> err_cnt=%0d sync=%0d", err_cnt_o, sync_o);
    tests++; if (err_cnt_o !== 8'd255) begin fails++; $display("FAIL sat_err_cnt: got %0d expected 255", err_cnt_o); end
    @(negedge clk);
    valid_i = 1'b1; pattern_i = 6'b010101; clr_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; clr_i = 1'b0;
    $display("[TB] clr with error sample -> err_cnt=%0d err=%0d", err_cnt_o, err_o);
    tests++; if (err_cnt_o !== 8'd0 || err_o !== 1'b0) begin fails++; $display("FAIL clr_priority: got cnt=%0d err=%0d expected 0/0", err_cnt_o, err_o); end
    tests++; if (sync_o !== 1'b0) begin fails++; $display("FAIL clr_state_update: got sync=%0d expected 0", sync_o); end
    @(negedge clk);
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL clr_err_after: got %0d expected 0", err_o); end
  endtask

  task automatic test_valid_low();
    @(negedge clk);
    valid_i = 1'b0; pattern_i = 6'b001000;
    repeat (5) @(negedge clk);
    $display("[TB] valid low x5 -> mode=%0d sync=%0d err_cnt=%0d", mode_o, sync_o, err_cnt_o);
    tests++; if (sync_o !== 1'b0 || mode_o !== 2'd1) begin fails++; $display("FAIL valid_low_hold: got sync=%0d mode=%0d expected sync=0 mode=1", sync_o, mode_o); end
    tests++; if (err_cnt_o !== 8'd0 || err_o !== 1'b0) begin fails++; $display("FAIL valid_low_err: got cnt=%0d err=%0d expected 0/0", err_cnt_o, err_o); end
  endtask

  task automatic test_reset_mid();
    drive_sample(6'b111111);
    drive_sample(6'b111111);
    tests++; if (err_cnt_o !== 8'd1) begin fails++; $display("FAIL haz_repeat_err: got %0d expected 1", err_cnt_o); end
    drive_sample(6'b000000);
    drive_sample(6'b000000);
    drive_sample(6'b001000);
    drive_sample(6'b011000);
    tests++; if (mode_o !== 2'd1) begin fails++; $display("FAIL pre_reset_mode: got %0d expected 1", mode_o); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] async reset in L2 -> mode=%0d sync=%0d err=%0d err_cnt=%0d", mode_o, sync_o, err_o, err_cnt_o);
    tests++; if (mode_o !== 2'd0 || sync_o !== 1'b1 || err_o !== 1'b0 || err_cnt_o !== 8'd0 || sweep_cnt_o !== 8'd0) begin
      fails++; $display("FAIL async_reset: got mode=%0d sync=%0d err=%0d cnt=%0d/%0d expected 0/1/0/0/0", mode_o, sync_o, err_o, err_cnt_o, sweep_cnt_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_sample(6'b001000);
    tests++; if (err_cnt_o !== 8'd0 || mode_o !== 2'd1) begin fails++; $display("FAIL post_reset_idle: got cnt=%0d mode=%0d expected 0/1", err_cnt_o, mode_o); end
  endtask

  initial begin
    test_reset();
    test_left_sweep();
    test_hazard();
    test_skip_step();
    test_illegal_encoding();
    test_saturation_clear();
    test_valid_low();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
